// File: rtl/dpram_req_scheduler.sv
// dpram_req_scheduler
// Shares one single-clock true dual-port RAM among NUM_REQ requesters.
// Each cycle up to two requests are granted in round-robin order, the first
// to RAM port A and the next non-conflicting one to port B. A same-address
// pair that includes a write is never issued together. Every accepted request
// receives exactly one response one cycle later, carrying the RAM q of the
// port that served it; write-through RAM makes a write's response its data.
module dpram_req_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REQ    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         ram_addr_a,
    output logic [DATA_WIDTH-1:0]         ram_data_a,
    output logic                          ram_we_a,
    input  logic [DATA_WIDTH-1:0]         ram_q_a,
    output logic [ADDR_WIDTH-1:0]         ram_addr_b,
    output logic [DATA_WIDTH-1:0]         ram_data_b,
    output logic                          ram_we_b,
    input  logic [DATA_WIDTH-1:0]         ram_q_b,
    output logic [CNT_WIDTH-1:0]          collision_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Two accesses to one address must not share a cycle when either writes;
    // two reads of the same word are harmless on a true dual-port RAM.
    function automatic logic is_conflict(
        input logic [ADDR_WIDTH-1:0] addr_x,
        input logic                  we_x,
        input logic [ADDR_WIDTH-1:0] addr_y,
        input logic                  we_y
    );
        return (addr_x == addr_y) && (we_x || we_y);
    endfunction

    // Round-robin pointer and per-port response owners
    logic [IDX_W-1:0]     rr_ptr_r;
    logic                 own_a_valid_r;
    logic [IDX_W-1:0]     own_a_idx_r;
    logic                 own_b_valid_r;
    logic [IDX_W-1:0]     own_b_idx_r;
    logic [CNT_WIDTH-1:0] collision_cnt_r;

    // Arbitration results
    logic                 grant_a_s;
    logic [IDX_W-1:0]     idx_a_s;
    logic                 grant_b_s;
    logic [IDX_W-1:0]     idx_b_s;
    logic                 conflict_s;
    logic [IDX_W-1:0]     scan_idx_s;

    // Scan from rr_ptr: first valid goes to A, next valid non-conflicting goes to B
    always_comb begin
        grant_a_s  = 1'b0;
        idx_a_s    = {IDX_W{1'b0}};
        grant_b_s  = 1'b0;
        idx_b_s    = {IDX_W{1'b0}};
        conflict_s = 1'b0;
        scan_idx_s = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx_s = rr_ptr_r + IDX_W'(k);
            if (!rst && req_valid[scan_idx_s]) begin
                if (!grant_a_s) begin
                    grant_a_s = 1'b1;
                    idx_a_s   = scan_idx_s;
                end else if (!grant_b_s) begin
                    if (is_conflict(req_addr[idx_a_s*ADDR_WIDTH +: ADDR_WIDTH], req_we[idx_a_s],
                                    req_addr[scan_idx_s*ADDR_WIDTH +: ADDR_WIDTH], req_we[scan_idx_s])) begin
                        conflict_s = 1'b1;
                    end else begin
                        grant_b_s = 1'b1;
                        idx_b_s   = scan_idx_s;
                    end
                end else begin
                    conflict_s = conflict_s;
                end
            end else begin
                conflict_s = conflict_s;
            end
        end
    end

    // Grant vector: only the requesters placed on a port see ready
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (grant_a_s) begin
            req_ready[idx_a_s] = 1'b1;
        end else begin
            req_ready = req_ready;
        end
        if (grant_b_s) begin
            req_ready[idx_b_s] = 1'b1;
        end else begin
            req_ready = req_ready;
        end
    end

    // Port A drive: granted requester's access, otherwise an idle all-zero port
    always_comb begin
        if (grant_a_s) begin
            ram_addr_a = req_addr[idx_a_s*ADDR_WIDTH +: ADDR_WIDTH];
            ram_data_a = req_wdata[idx_a_s*DATA_WIDTH +: DATA_WIDTH];
            ram_we_a   = req_we[idx_a_s];
        end else begin
            ram_addr_a = {ADDR_WIDTH{1'b0}};
            ram_data_a = {DATA_WIDTH{1'b0}};
            ram_we_a   = 1'b0;
        end
    end

    // Port B drive: granted requester's access, otherwise an idle all-zero port
    always_comb begin
        if (grant_b_s) begin
            ram_addr_b = req_addr[idx_b_s*ADDR_WIDTH +: ADDR_WIDTH];
            ram_data_b = req_wdata[idx_b_s*DATA_WIDTH +: DATA_WIDTH];
            ram_we_b   = req_we[idx_b_s];
        end else begin
            ram_addr_b = {ADDR_WIDTH{1'b0}};
            ram_data_b = {DATA_WIDTH{1'b0}};
            ram_we_b   = 1'b0;
        end
    end

    // Advance the pointer past the last requester granted this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= {IDX_W{1'b0}};
        end else if (grant_b_s) begin
            rr_ptr_r <= idx_b_s + IDX_W'(1'b1);
        end else if (grant_a_s) begin
            rr_ptr_r <= idx_a_s + IDX_W'(1'b1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Count cycles in which a conflict deferred someone, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            collision_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (conflict_s && (collision_cnt_r != {CNT_WIDTH{1'b1}})) begin
            collision_cnt_r <= collision_cnt_r + CNT_WIDTH'(1'b1);
        end else begin
            collision_cnt_r <= collision_cnt_r;
        end
    end

    assign collision_cnt = collision_cnt_r;

    // Remember which requester each port served so its q can be routed back
    always_ff @(posedge clk) begin
        if (rst) begin
            own_a_valid_r <= 1'b0;
            own_a_idx_r   <= {IDX_W{1'b0}};
            own_b_valid_r <= 1'b0;
            own_b_idx_r   <= {IDX_W{1'b0}};
        end else begin
            own_a_valid_r <= grant_a_s;
            own_a_idx_r   <= grant_a_s ? idx_a_s : {IDX_W{1'b0}};
            own_b_valid_r <= grant_b_s;
            own_b_idx_r   <= grant_b_s ? idx_b_s : {IDX_W{1'b0}};
        end
    end

    // Route port q to its owner; suppressed in reset so in-flight responses are dropped
    always_comb begin
        rsp_valid = {NUM_REQ{1'b0}};
        rsp_rdata = {(NUM_REQ*DATA_WIDTH){1'b0}};
        if (!rst) begin
            if (own_a_valid_r) begin
                rsp_valid[own_a_idx_r]                            = 1'b1;
                rsp_rdata[own_a_idx_r*DATA_WIDTH +: DATA_WIDTH]   = ram_q_a;
            end else begin
                rsp_valid = rsp_valid;
            end
            if (own_b_valid_r) begin
                rsp_valid[own_b_idx_r]                            = 1'b1;
                rsp_rdata[own_b_idx_r*DATA_WIDTH +: DATA_WIDTH]   = ram_q_b;
            end else begin
                rsp_valid = rsp_valid;
            end
        end else begin
            rsp_valid = {NUM_REQ{1'b0}};
        end
    end

endmodule
